slsr_param: RTL and testbench

Parametrised successor to the 8-bit shift-left/shift-right register. It generalises width and adds four features:
- parallel load,
- rotate mode,
- a counted burst-shift engine with a busy/done handshake,
- an error flag for illegal direction requests.

It sits in the datapath wherever serial/parallel conversion or timed bit-shifting is needed. It replaces fixed-width single-step instances.

---
 rtl/slsr_param.sv | 119 +++++++++++
 tb/tb_slsr_param.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/slsr_param.sv
// Parametrised shift-left/shift-right register with parallel load, rotate mode,
// counted burst-shift engine (busy/done) and an illegal-request error flag.
module slsr_param #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sl,
   input  logic             sr,
   input  logic             rot,
   input  logic             din,
   input  logic             load,
   input  logic [WIDTH-1:0] pdin,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] Q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done,
   output logic             err
);

   // S_ZERO holds a count=0 burst for one cycle so done lands a cycle later
   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_ZERO
   } state_t;

   state_t           r_state, w_state_nx;
   logic [WIDTH-1:0] r_q, w_q_nx;
   logic [CNT_W-1:0] r_rem, w_rem_nx;
   logic             r_dir, w_dir_nx;
   logic             r_done, w_done_nx;
   logic             r_err, w_err_nx;

   function automatic logic [WIDTH-1:0] f_shift(
      input logic [WIDTH-1:0] q,
      input logic             left,
      input logic             rt,
      input logic             d
   );
      if (left)
         f_shift = {q[WIDTH-2:0], rt ? q[WIDTH-1] : d};
      else
         f_shift = {rt ? q[0] : d, q[WIDTH-1:1]};
   endfunction

   always_comb begin
      w_state_nx = r_state;
      w_q_nx     = r_q;
      w_rem_nx   = r_rem;
      w_dir_nx   = r_dir;
      w_done_nx  = 1'b0;
      w_err_nx   = 1'b0;
      if (load) begin
         w_q_nx     = pdin;
         w_state_nx = S_IDLE;
      end else begin
         unique case (r_state)
            S_RUN: begin
               w_q_nx   = f_shift(r_q, r_dir, rot, din);
               w_rem_nx = r_rem - 1'b1;
               if (r_rem == CNT_W'(1)) begin
                  w_state_nx = S_IDLE;
                  w_done_nx  = 1'b1;
               end
            end
            S_ZERO: begin
               w_state_nx = S_IDLE;
               w_done_nx  = 1'b1;
            end
            default: begin
               if (start) begin
                  if (sl ^ sr) begin
                     w_dir_nx   = sl;
                     w_rem_nx   = count;
                     w_state_nx = (count != '0) ? S_RUN : S_ZERO;
                  end else begin
                     w_err_nx = 1'b1;
                  end
               end else if (sl && sr) begin
                  w_err_nx = 1'b1;
               end else if (sl || sr) begin
                  w_q_nx = f_shift(r_q, sl, rot, din);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_rem   <= '0;
         r_dir   <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_q     <= w_q_nx;
         r_rem   <= w_rem_nx;
         r_dir   <= w_dir_nx;
         r_done  <= w_done_nx;
         r_err   <= w_err_nx;
      end
   end

   assign Q      = r_q;
   assign sout_l = r_q[WIDTH-1];
   assign sout_r = r_q[0];
   assign busy   = (r_state == S_RUN);
   assign done   = r_done;
   assign err    = r_err;

endmodule

// File: tb/tb_slsr_param.sv
// Bench for slsr_param: behavioural model with per-cycle compare, directed
// literal checks, random stimulus, and a 16-bit instance for the wide burst.
module tb_slsr_param;

   logic        clk = 1'b0;
   logic        reset, sl, sr, rot, din, load, start;
   logic [7:0]  pdin8;
   logic [3:0]  cnt4;
   logic [15:0] pdin16;
   logic [4:0]  cnt5;
   logic [7:0]  q8;
   logic        sl8, sr8, busy8, done8, err8;
   logic [15:0] q16;
   logic        sl16, sr16, busy16, done16, err16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   slsr_param #(.WIDTH(8), .CNT_W(4)) u_dut8 (
      .clk(clk), .reset(reset), .sl(sl), .sr(sr), .rot(rot), .din(din),
      .load(load), .pdin(pdin8), .start(start), .count(cnt4),
      .Q(q8), .sout_l(sl8), .sout_r(sr8), .busy(busy8), .done(done8),
      .err(err8)
   );

   slsr_param #(.WIDTH(16), .CNT_W(5)) u_dut16 (
      .clk(clk), .reset(reset), .sl(sl), .sr(sr), .rot(rot), .din(din),
      .load(load), .pdin(pdin16), .start(start), .count(cnt5),
      .Q(q16), .sout_l(sl16), .sout_r(sr16), .busy(busy16), .done(done16),
      .err(err16)
   );

   // Behavioural model of the 8-bit instance
   int  m_q, m_rem;
   bit  m_busy, m_zero, m_left, m_done, m_err, m_valid = 0;

   function automatic int shl(int q, bit fill);
      return ((q << 1) & 8'hFF) | int'(fill);
   endfunction

   function automatic int shr(int q, bit fill);
      return (q >> 1) | (int'(fill) << 7);
   endfunction

   always @(posedge clk) begin
      m_done = 0;
      m_err  = 0;
      if (reset) begin
         m_q = 0; m_busy = 0; m_zero = 0; m_rem = 0; m_valid = 1;
      end else if (load) begin
         m_q = int'(pdin8); m_busy = 0; m_zero = 0;
      end else if (m_busy) begin
         if (m_left) m_q = shl(m_q, rot ? m_q[7] : din);
         else        m_q = shr(m_q, rot ? m_q[0] : din);
         m_rem = m_rem - 1;
         if (m_rem == 0) begin m_busy = 0; m_done = 1; end
      end else if (m_zero) begin
         m_zero = 0; m_done = 1;
      end else if (start) begin
         if (sl != sr) begin
            m_left = sl;
            m_rem  = int'(cnt4);
            if (m_rem != 0) m_busy = 1; else m_zero = 1;
         end else m_err = 1;
      end else if (sl && sr) m_err = 1;
      else if (sl) m_q = shl(m_q, rot ? m_q[7] : din);
      else if (sr) m_q = shr(m_q, rot ? m_q[0] : din);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_q", int'(q8), m_q);
         chk("model_busy", int'(busy8), int'(m_busy));
         chk("model_done", int'(done8), int'(m_done));
         chk("model_err", int'(err8), int'(m_err));
         chk("model_sout_l", int'(sl8), int'(m_q[7]));
         chk("model_sout_r", int'(sr8), int'(m_q[0]));
         chk("done_err_excl", int'(done8 & err8), 0);
      end
   end

   task automatic idle();
      reset = 0; sl = 0; sr = 0; rot = 0; din = 0; load = 0; start = 0;
      pdin8 = 0; cnt4 = 0; pdin16 = 0; cnt5 = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load8(input logic [7:0] v);
      idle(); load = 1; pdin8 = v; tick(); idle();
   endtask

   initial begin
      idle();
      reset = 1; tick(); idle();
      chk("reset_q", int'(q8), 0);
      chk("reset_flags", int'({busy8, done8, err8}), 0);

      sl = 1; din = 1; repeat (3) tick();
      chk("step_sl3", int'(q8), 'h07);
      idle(); sr = 1; repeat (2) tick();
      chk("step_sr2", int'(q8), 'h01);

      load8(8'h96);
      chk("load", int'(q8), 'h96);
      rot = 1; sl = 1; tick();
      chk("rot_l", int'(q8), 'h2D);
      idle(); rot = 1; sr = 1; tick();
      chk("rot_r1", int'(q8), 'h96);
      tick();
      chk("rot_r2", int'(q8), 'h4B);
      tick();
      chk("rot_r3", int'(q8), 'hA5);

      load8(8'h01);
      start = 1; sl = 1; cnt4 = 5; tick(); idle();
      chk("burst_busy0", int'(busy8), 1);
      chk("burst_noshift", int'(q8), 'h01);
      for (int i = 0; i < 4; i++) tick();
      chk("burst_busy4", int'(busy8), 1);
      chk("burst_q4", int'(q8), 'h10);
      tick();
      chk("burst_q5", int'(q8), 'h20);
      chk("burst_end", int'({busy8, done8}), 'b01);
      tick();
      chk("burst_done_once", int'(done8), 0);

      sl = 1; sr = 1; tick(); idle();
      chk("step_both_err", int'(err8), 1);
      chk("step_both_hold", int'(q8), 'h20);
      tick();
      chk("err_pulse", int'(err8), 0);

      start = 1; cnt4 = 3; tick(); idle();
      chk("start_nodir_err", int'({busy8, err8}), 'b01);

      start = 1; sr = 1; cnt4 = 0; tick(); idle();
      chk("cnt0_first", int'({busy8, done8}), 0);
      tick();
      chk("cnt0_done", int'({busy8, done8}), 'b01);
      chk("cnt0_q", int'(q8), 'h20);

      load8(8'h01);
      start = 1; sl = 1; cnt4 = 3; tick();
      idle(); start = 1; sr = 1; cnt4 = 1; tick(); idle();
      chk("restart_noerr", int'(err8), 0);
      tick(); tick();
      chk("restart_ign", int'(q8), 'h08);
      chk("restart_done", int'(done8), 1);

      load8(8'h01);
      start = 1; sl = 1; cnt4 = 7; tick(); idle();
      tick(); tick();
      load = 1; pdin8 = 8'hA5; tick(); idle();
      chk("abort_load", int'({q8, busy8, done8}), {8'hA5, 2'b00});
      repeat (6) begin
         tick();
         chk("abort_load_nodone", int'(done8), 0);
      end

      load8(8'h01);
      start = 1; sl = 1; cnt4 = 7; tick(); idle();
      tick(); tick();
      reset = 1; tick(); idle();
      chk("abort_reset", int'({q8, busy8, done8}), 0);
      repeat (6) begin
         tick();
         chk("abort_reset_nodone", int'(done8), 0);
      end

      load = 1; pdin16 = 16'h8001; tick(); idle();
      start = 1; sr = 1; rot = 1; cnt5 = 16; tick(); idle(); rot = 1;
      repeat (15) tick();
      chk("w16_busy15", int'(busy16), 1);
      chk("w16_q15", int'(q16), 'h0003);
      tick();
      chk("w16_q16", int'(q16), 'h8001);
      chk("w16_done", int'({busy16, done16}), 'b01);
      idle();

      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(63) == 0);
         load  = ($urandom_range(15) == 0);
         start = ($urandom_range(3) == 0);
         sl    = 1'($urandom);
         sr    = 1'($urandom);
         rot   = 1'($urandom);
         din   = 1'($urandom);
         pdin8 = 8'($urandom);
         cnt4  = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(6));
         pdin16 = 16'($urandom);
         cnt5  = 5'($urandom);
         tick();
      end
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
